// File: rtl/seq_cmp_pkg.sv
// Shared types and sizing helpers for the sequential magnitude comparator.
//   cmp_state_e  : FSM states IDLE / CMP / DONE
//   cmp_result_t : one-hot compare result {eq, lt, gt}
//   cmp_ndig     : number of DIGIT-wide digits in a WIDTH-bit operand
//   cmp_idx_w    : width of the digit index register (at least 1 bit)
package seq_cmp_pkg;

  localparam int CMP_DEF_WIDTH = 32;
  localparam int CMP_DEF_DIGIT = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMP  = 2'd1,
    DONE = 2'd2
  } cmp_state_e;

  typedef struct packed {
    logic eq;
    logic lt;
    logic gt;
  } cmp_result_t;

  function automatic int cmp_ndig(input int w, input int d);
    return w / d;
  endfunction

  function automatic int cmp_idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mag_cmp_digit.sv
// Combinational unsigned magnitude compare of one DIGIT-bit digit.
//   a, b       : digit operands
//   eq, lt, gt : a == b, a < b, a > b (exactly one is high)
module mag_cmp_digit #(
  parameter int DIGIT = 4
) (
  input  logic [DIGIT-1:0] a,
  input  logic [DIGIT-1:0] b,
  output logic             eq,
  output logic             lt,
  output logic             gt
);

  assign eq = (a == b);
  assign lt = (a <  b);
  assign gt = (a >  b);

endmodule

// File: rtl/seq_mag_comparator.sv
// Multi-cycle magnitude comparator, MSB digit first, DIGIT bits per cycle.
// Signed compares are turned into unsigned ones by flipping the sign bit of
// both operands on accept (offset binary).
//
// Ports:
//   i_clk, i_rst_n            : clock, async active-low reset
//   i_req_valid / o_req_ready : request handshake (ready only in IDLE)
//   i_a, i_b, i_signed        : operands and mode, sampled on accept only
//   i_flush                   : abort an in-flight compare (CMP or DONE)
//   o_resp_valid / i_resp_ready : response handshake, held until taken
//   o_eq, o_lt, o_gt          : one-hot result while o_resp_valid, else 0
//
// Build option: SEQ_CMP_EARLY_EXIT_EN
//   defined   : stop at the first differing digit (latency 1..NDIG)
//   undefined : always walk all NDIG digits (fixed latency NDIG); the
//               highest differing digit is latched and decides lt/gt.
// WIDTH must be a multiple of DIGIT.
module seq_mag_comparator import seq_cmp_pkg::*; #(
  parameter int WIDTH = CMP_DEF_WIDTH,
  parameter int DIGIT = CMP_DEF_DIGIT
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_req_valid,
  output logic             o_req_ready,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic             i_signed,
  input  logic             i_flush,
  output logic             o_resp_valid,
  input  logic             i_resp_ready,
  output logic             o_eq,
  output logic             o_lt,
  output logic             o_gt
);

  localparam int NDIG = cmp_ndig(WIDTH, DIGIT);
  localparam int IW   = cmp_idx_w(NDIG);

  cmp_state_e  state, state_n;
  logic [IW-1:0] idx;
  logic [WIDTH-1:0] a_r, b_r;
  cmp_result_t res, fin_res;
  logic        accept, finish;

  // digit currently under inspection
  logic [WIDTH-1:0] a_sh, b_sh;
  logic [DIGIT-1:0] a_dig, b_dig;
  logic             d_eq, d_lt, d_gt;

  assign a_sh  = a_r >> (DIGIT * int'(idx));
  assign b_sh  = b_r >> (DIGIT * int'(idx));
  assign a_dig = a_sh[DIGIT-1:0];
  assign b_dig = b_sh[DIGIT-1:0];

  mag_cmp_digit #(.DIGIT(DIGIT)) u_dig (
    .a  (a_dig),
    .b  (b_dig),
    .eq (d_eq),
    .lt (d_lt),
    .gt (d_gt)
  );

`ifndef SEQ_CMP_EARLY_EXIT_EN
  // first (most significant) differing digit seen during the walk
  logic hit_r, hit_lt_r;
`endif

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state <= IDLE;
    else          state <= state_n;
  end

  always_comb begin
    state_n     = state;
    accept      = 1'b0;
    finish      = 1'b0;
    fin_res     = '0;
    o_req_ready = (state == IDLE);
    case (state)
      IDLE: begin
        if (i_req_valid) begin
          accept  = 1'b1;
          state_n = CMP;
        end
      end
      CMP: begin
        if (i_flush) begin
          state_n = IDLE;
        end else begin
`ifdef SEQ_CMP_EARLY_EXIT_EN
          if (!d_eq) begin
            finish  = 1'b1;
            fin_res = '{eq: 1'b0, lt: d_lt, gt: d_gt};
          end else if (idx == '0) begin
            finish  = 1'b1;
            fin_res = '{eq: 1'b1, lt: 1'b0, gt: 1'b0};
          end
`else
          if (idx == '0) begin
            finish = 1'b1;
            if (hit_r)      fin_res = '{eq: 1'b0, lt: hit_lt_r, gt: !hit_lt_r};
            else if (!d_eq) fin_res = '{eq: 1'b0, lt: d_lt, gt: d_gt};
            else            fin_res = '{eq: 1'b1, lt: 1'b0, gt: 1'b0};
          end
`endif
          if (finish) state_n = DONE;
        end
      end
      DONE: begin
        // flush and handshake both return to IDLE
        if (i_flush || i_resp_ready) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      a_r      <= '0;
      b_r      <= '0;
      idx      <= IW'(NDIG - 1);
      res      <= '0;
`ifndef SEQ_CMP_EARLY_EXIT_EN
      hit_r    <= 1'b0;
      hit_lt_r <= 1'b0;
`endif
    end else begin
      if (accept) begin
        a_r      <= {i_a[WIDTH-1] ^ i_signed, i_a[WIDTH-2:0]};
        b_r      <= {i_b[WIDTH-1] ^ i_signed, i_b[WIDTH-2:0]};
        idx      <= IW'(NDIG - 1);
`ifndef SEQ_CMP_EARLY_EXIT_EN
        hit_r    <= 1'b0;
        hit_lt_r <= 1'b0;
`endif
      end else if (state == CMP && !i_flush) begin
        if (idx != '0) idx <= idx - 1'b1;
`ifndef SEQ_CMP_EARLY_EXIT_EN
        if (!d_eq && !hit_r) begin
          hit_r    <= 1'b1;
          hit_lt_r <= d_lt;
        end
`endif
      end
      if (finish)                               res <= fin_res;
      else if (state != IDLE && state_n == IDLE) res <= '0;
    end
  end

  assign o_resp_valid = (state == DONE);
  assign o_eq = o_resp_valid & res.eq;
  assign o_lt = o_resp_valid & res.lt;
  assign o_gt = o_resp_valid & res.gt;

endmodule
